// File: rtl/quadrature_position_tracker.sv
// rtl/quadrature_position_tracker.sv - hysteresis I/Q comparator, quadrature decoder and AXIS position stream.
// Stage 1 squares up each channel; stage 2 decodes the Gray state into a signed position.
module quadrature_position_tracker #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int POSITION_WIDTH   = 32,
  parameter int ERR_WIDTH        = 16,
  parameter bit SATURATE         = 1'b0
) (
  input  logic                          SYS_aclk,
  input  logic                          SYS_reset,
  input  logic [AXIS_TDATA_WIDTH/2-1:0] FC_lower_threshold,
  input  logic [AXIS_TDATA_WIDTH/2-1:0] FC_upper_threshold,
  input  logic [1:0]                    FC_mode,
  input  logic                          FC_clear,
  input  logic                          S_AXIS_tvalid,
  input  logic [AXIS_TDATA_WIDTH-1:0]   S_AXIS_tdata,
  output logic                          S_AXIS_tready,
  input  logic                          M_AXIS_tready,
  output logic                          M_AXIS_tvalid,
  output logic [POSITION_WIDTH-1:0]     M_AXIS_tdata,
  output logic [ERR_WIDTH-1:0]          ERR_count,
  output logic                          ERR_drop
);

  localparam int HW = AXIS_TDATA_WIDTH / 2;
  localparam logic [POSITION_WIDTH-1:0] POS_ONE = {{(POSITION_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [POSITION_WIDTH-1:0] POS_MAX = {1'b0, {(POSITION_WIDTH-1){1'b1}}};
  localparam logic [POSITION_WIDTH-1:0] POS_MIN = {1'b1, {(POSITION_WIDTH-1){1'b0}}};
  localparam logic [ERR_WIDTH-1:0]      ERR_ONE = {{(ERR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {INIT, TRACK} state_t;

  logic signed [HW:0] a_ext, b_ext, lo_ext, hi_ext;
  logic               a_bit, b_bit, a_dec, b_dec, s1_valid;
  logic [1:0]         s1_mode;
  state_t             state, state_next;
  logic [1:0]         prev, cur, diff;
  logic               fwd, emit, load_prev, cnt_up, cnt_dn, illegal;
  logic [POSITION_WIDTH-1:0] pos, pos_next;
  logic [ERR_WIDTH-1:0]      err;
  logic                      m_valid, drop;

  assign S_AXIS_tready = 1'b1;

  // One extra bit keeps the signed compare exact at the extremes of the sample range.
  assign a_ext  = {S_AXIS_tdata[HW-1], S_AXIS_tdata[HW-1:0]};
  assign b_ext  = {S_AXIS_tdata[2*HW-1], S_AXIS_tdata[2*HW-1:HW]};
  assign lo_ext = {FC_lower_threshold[HW-1], FC_lower_threshold};
  assign hi_ext = {FC_upper_threshold[HW-1], FC_upper_threshold};

  always_ff @(posedge SYS_aclk) begin
    if (SYS_reset) begin
      a_bit <= 1'b0; a_dec <= 1'b0;
      b_bit <= 1'b0; b_dec <= 1'b0;
      s1_valid <= 1'b0;
      s1_mode  <= 2'b00;
    end else begin
      s1_valid <= S_AXIS_tvalid;
      if (S_AXIS_tvalid) begin
        s1_mode <= FC_mode;
        if (a_ext < lo_ext)      begin a_bit <= 1'b0; a_dec <= 1'b1; end
        else if (a_ext > hi_ext) begin a_bit <= 1'b1; a_dec <= 1'b1; end
        if (b_ext < lo_ext)      begin b_bit <= 1'b0; b_dec <= 1'b1; end
        else if (b_ext > hi_ext) begin b_bit <= 1'b1; b_dec <= 1'b1; end
      end
    end
  end

  assign cur  = {a_bit, b_bit};
  assign diff = cur ^ prev;
  assign fwd  = (prev == 2'b00 && cur == 2'b10) || (prev == 2'b10 && cur == 2'b11) ||
                (prev == 2'b11 && cur == 2'b01) || (prev == 2'b01 && cur == 2'b00);

  always_ff @(posedge SYS_aclk) begin
    if (SYS_reset) state <= INIT;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (state == INIT && s1_valid && a_dec && b_dec) state_next = TRACK;
  end

  always_comb begin
    emit = 1'b0; load_prev = 1'b0; cnt_up = 1'b0; cnt_dn = 1'b0; illegal = 1'b0;
    case (state)
      INIT: load_prev = s1_valid && a_dec && b_dec;
      TRACK: begin
        if (s1_valid) begin
          emit      = 1'b1;
          load_prev = 1'b1;
          if (diff == 2'b11) illegal = 1'b1;
          else if (diff != 2'b00) begin
            case (s1_mode)
              2'b01: begin
                cnt_up = (prev == 2'b00) && (cur == 2'b10);
                cnt_dn = (prev == 2'b10) && (cur == 2'b00);
              end
              2'b10: begin
                cnt_up = diff[1] && fwd;
                cnt_dn = diff[1] && !fwd;
              end
              default: begin
                cnt_up = fwd;
                cnt_dn = !fwd;
              end
            endcase
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    pos_next = pos;
    if (cnt_up && !(SATURATE && pos == POS_MAX)) pos_next = pos + POS_ONE;
    if (cnt_dn && !(SATURATE && pos == POS_MIN)) pos_next = pos - POS_ONE;
  end

  // Output tdata is the position register itself: every emitted beat carries the newest position.
  always_ff @(posedge SYS_aclk) begin
    if (SYS_reset) begin
      prev    <= 2'b00;
      pos     <= '0;
      err     <= '0;
      drop    <= 1'b0;
      m_valid <= 1'b0;
    end else begin
      if (FC_clear) begin
        pos  <= '0;
        err  <= '0;
        drop <= 1'b0;
        prev <= cur;
      end else begin
        pos <= pos_next;
        if (illegal && err != '1) err <= err + ERR_ONE;
        if (emit && m_valid && !M_AXIS_tready) drop <= 1'b1;
        if (load_prev) prev <= cur;
      end
      if (emit)               m_valid <= 1'b1;
      else if (M_AXIS_tready) m_valid <= 1'b0;
    end
  end

  assign M_AXIS_tvalid = m_valid;
  assign M_AXIS_tdata  = pos;
  assign ERR_count     = err;
  assign ERR_drop      = drop;

endmodule

// File: tb/tb_quadrature_position_tracker.sv
// tb/tb_quadrature_position_tracker.sv - directed bench for quadrature_position_tracker.
// Three instances share stimulus: 32-bit wrapping, 8-bit saturating and 8-bit wrapping.
module tb_quadrature_position_tracker;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] lo, hi;
  logic [1:0]  mode;
  logic        clr;
  logic        s_tvalid;
  logic [31:0] s_tdata;
  logic        m_tready;

  logic        s_tready, m_tvalid, drop;
  logic [31:0] m_tdata;
  logic [15:0] err;
  logic        sat_sready, sat_tvalid, sat_drop;
  logic [7:0]  sat_tdata;
  logic [15:0] sat_err;
  logic        wrp_sready, wrp_tvalid, wrp_drop;
  logic [7:0]  wrp_tdata;
  logic [15:0] wrp_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  quadrature_position_tracker #(.AXIS_TDATA_WIDTH(32), .POSITION_WIDTH(32), .ERR_WIDTH(16), .SATURATE(1'b0)) dut (
    .SYS_aclk(clk), .SYS_reset(rst), .FC_lower_threshold(lo), .FC_upper_threshold(hi),
    .FC_mode(mode), .FC_clear(clr), .S_AXIS_tvalid(s_tvalid), .S_AXIS_tdata(s_tdata),
    .S_AXIS_tready(s_tready), .M_AXIS_tready(m_tready), .M_AXIS_tvalid(m_tvalid),
    .M_AXIS_tdata(m_tdata), .ERR_count(err), .ERR_drop(drop));

  quadrature_position_tracker #(.AXIS_TDATA_WIDTH(32), .POSITION_WIDTH(8), .ERR_WIDTH(16), .SATURATE(1'b1)) dut_sat (
    .SYS_aclk(clk), .SYS_reset(rst), .FC_lower_threshold(lo), .FC_upper_threshold(hi),
    .FC_mode(mode), .FC_clear(clr), .S_AXIS_tvalid(s_tvalid), .S_AXIS_tdata(s_tdata),
    .S_AXIS_tready(sat_sready), .M_AXIS_tready(m_tready), .M_AXIS_tvalid(sat_tvalid),
    .M_AXIS_tdata(sat_tdata), .ERR_count(sat_err), .ERR_drop(sat_drop));

  quadrature_position_tracker #(.AXIS_TDATA_WIDTH(32), .POSITION_WIDTH(8), .ERR_WIDTH(16), .SATURATE(1'b0)) dut_wrp (
    .SYS_aclk(clk), .SYS_reset(rst), .FC_lower_threshold(lo), .FC_upper_threshold(hi),
    .FC_mode(mode), .FC_clear(clr), .S_AXIS_tvalid(s_tvalid), .S_AXIS_tdata(s_tdata),
    .S_AXIS_tready(wrp_sready), .M_AXIS_tready(m_tready), .M_AXIS_tvalid(wrp_tvalid),
    .M_AXIS_tdata(wrp_tdata), .ERR_count(wrp_err), .ERR_drop(wrp_drop));

  // Gray state {A,B} to a beat with each channel well outside the +/-100 band.
  function automatic logic [31:0] enc(input logic [1:0] s);
    logic [15:0] a, b;
    a = s[1] ? 16'd500 : 16'hFE0C;
    b = s[0] ? 16'd500 : 16'hFE0C;
    return {b, a};
  endfunction

  function automatic logic [1:0] fwd_state(input int i);
    case (i % 4)
      0: return 2'b10;
      1: return 2'b11;
      2: return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] rev_state(input int i);
    case (i % 4)
      0: return 2'b01;
      1: return 2'b11;
      2: return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // Drives one beat and returns at the sample point two edges after acceptance.
  task automatic beat_raw(input logic [31:0] d);
    @(negedge clk); s_tvalid = 1'b1; s_tdata = d;
    @(negedge clk); s_tvalid = 1'b0;
    @(negedge clk);
  endtask

  task automatic beat(input logic [1:0] s);
    beat_raw(enc(s));
  endtask

  task automatic beat_ab(input int a, input int b);
    logic [31:0] av, bv;
    av = a; bv = b;
    beat_raw({bv[15:0], av[15:0]});
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; s_tvalid = 1'b0; clr = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid got %0b want 0", m_tvalid); end
    n_vec++; if (m_tdata !== 32'd0) begin n_err++; $display("FAIL reset_tdata got %h want 0", m_tdata); end
    n_vec++; if (err !== 16'd0) begin n_err++; $display("FAIL reset_err got %0d want 0", err); end
    n_vec++; if (drop !== 1'b0) begin n_err++; $display("FAIL reset_drop got %0b want 0", drop); end
    n_vec++; if (s_tready !== 1'b1) begin n_err++; $display("FAIL s_tready got %0b want 1", s_tready); end
  endtask

  task automatic test_init();
    mode = 2'b00;
    do_reset();
    beat_ab(200, -200);
    n_vec++; if (m_tvalid !== 1'b0 || m_tdata !== 32'd0) begin n_err++; $display("FAIL init_no_beat got v=%0b d=%h want v=0 d=0", m_tvalid, m_tdata); end
    beat_ab(200, 200);
    n_vec++; if (m_tvalid !== 1'b1 || m_tdata !== 32'd1) begin n_err++; $display("FAIL init_first_step got v=%0b d=%h want v=1 d=1", m_tvalid, m_tdata); end
  endtask

  task automatic test_x4();
    mode = 2'b00;
    do_reset();
    beat(2'b00);
    for (int i = 0; i < 4; i++) begin
      beat(fwd_state(i));
      n_vec++; if (m_tdata !== 32'(i + 1) || m_tvalid !== 1'b1) begin n_err++; $display("FAIL x4_fwd[%0d] got %h v=%0b want %h", i, m_tdata, m_tvalid, 32'(i + 1)); end
    end
    for (int i = 0; i < 4; i++) begin
      beat(rev_state(i));
      n_vec++; if (m_tdata !== 32'(3 - i)) begin n_err++; $display("FAIL x4_rev[%0d] got %h want %h", i, m_tdata, 32'(3 - i)); end
    end
  endtask

  task automatic test_x2_x1();
    logic [31:0] exp_x2 [4];
    exp_x2[0] = 32'd1; exp_x2[1] = 32'd1; exp_x2[2] = 32'd2; exp_x2[3] = 32'd2;
    mode = 2'b10;
    do_reset();
    beat(2'b00);
    for (int i = 0; i < 4; i++) begin
      beat(fwd_state(i));
      n_vec++; if (m_tdata !== exp_x2[i]) begin n_err++; $display("FAIL x2_fwd[%0d] got %h want %h", i, m_tdata, exp_x2[i]); end
    end
    mode = 2'b01;
    do_reset();
    beat(2'b00);
    for (int i = 0; i < 4; i++) begin
      beat(fwd_state(i));
      n_vec++; if (m_tdata !== 32'd1) begin n_err++; $display("FAIL x1_fwd[%0d] got %h want 1", i, m_tdata); end
    end
    do_reset();
    beat(2'b00);
    for (int i = 0; i < 40; i++) beat(rev_state(i));
    n_vec++; if (m_tdata !== 32'hFFFF_FFF6) begin n_err++; $display("FAIL x1_rev10 got %h want fffffff6", m_tdata); end
  endtask

  task automatic test_hysteresis();
    int vals [5];
    vals[0] = 50; vals[1] = -50; vals[2] = 100; vals[3] = -100; vals[4] = 50;
    mode = 2'b00;
    do_reset();
    beat(2'b00);
    for (int i = 0; i < 5; i++) begin
      beat_ab(vals[i], -500);
      n_vec++; if (m_tdata !== 32'd0 || err !== 16'd0) begin n_err++; $display("FAIL hyst[%0d] got d=%h e=%0d want d=0 e=0", i, m_tdata, err); end
    end
    beat(2'b11);
    n_vec++; if (err !== 16'd1 || m_tdata !== 32'd0 || m_tvalid !== 1'b1) begin n_err++; $display("FAIL illegal_jump got e=%0d d=%h v=%0b want e=1 d=0 v=1", err, m_tdata, m_tvalid); end
    beat_ab(-100, 500);
    n_vec++; if (m_tdata !== 32'd0) begin n_err++; $display("FAIL band_edge_hold got %h want 0", m_tdata); end
    beat_ab(-101, 500);
    n_vec++; if (m_tdata !== 32'd1) begin n_err++; $display("FAIL band_edge_cross got %h want 1", m_tdata); end
  endtask

  task automatic test_back_to_back();
    mode = 2'b00; m_tready = 1'b1;
    do_reset();
    beat(2'b00);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); s_tvalid = 1'b1; s_tdata = enc(fwd_state(i));
    end
    @(negedge clk); s_tvalid = 1'b0;
    @(negedge clk);
    n_vec++; if (m_tdata !== 32'd4 || m_tvalid !== 1'b1 || drop !== 1'b0) begin n_err++; $display("FAIL b2b got d=%h v=%0b drop=%0b want d=4 v=1 drop=0", m_tdata, m_tvalid, drop); end
    @(negedge clk); s_tvalid = 1'b1; s_tdata = enc(2'b10);
    @(negedge clk); s_tvalid = 1'b0; clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    n_vec++; if (m_tdata !== 32'd0 || m_tvalid !== 1'b1) begin n_err++; $display("FAIL clear_coincident got d=%h v=%0b want d=0 v=1", m_tdata, m_tvalid); end
    beat(2'b11);
    n_vec++; if (m_tdata !== 32'd1) begin n_err++; $display("FAIL after_clear got %h want 1", m_tdata); end
  endtask

  task automatic test_drop_and_reset();
    mode = 2'b00; m_tready = 1'b1;
    do_reset();
    beat(2'b00);
    m_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); s_tvalid = 1'b1; s_tdata = enc(fwd_state(i));
    end
    @(negedge clk); s_tvalid = 1'b0;
    @(negedge clk);
    n_vec++; if (m_tdata !== 32'd3 || m_tvalid !== 1'b1 || drop !== 1'b1) begin n_err++; $display("FAIL drop got d=%h v=%0b drop=%0b want d=3 v=1 drop=1", m_tdata, m_tvalid, drop); end
    repeat (2) @(negedge clk);
    n_vec++; if (m_tvalid !== 1'b1 || m_tdata !== 32'd3) begin n_err++; $display("FAIL hold got v=%0b d=%h want v=1 d=3", m_tvalid, m_tdata); end
    m_tready = 1'b1;
    @(negedge clk);
    n_vec++; if (m_tvalid !== 1'b0 || drop !== 1'b1) begin n_err++; $display("FAIL accept got v=%0b drop=%0b want v=0 drop=1", m_tvalid, drop); end
    m_tready = 1'b0;
    beat(2'b00);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    n_vec++; if (m_tvalid !== 1'b0 || m_tdata !== 32'd0 || drop !== 1'b0) begin n_err++; $display("FAIL mid_reset got v=%0b d=%h drop=%0b want 0 0 0", m_tvalid, m_tdata, drop); end
    m_tready = 1'b1;
    beat(2'b10);
    n_vec++; if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL reinit_no_beat got v=%0b want 0", m_tvalid); end
    beat(2'b11);
    n_vec++; if (m_tdata !== 32'd1 || m_tvalid !== 1'b1) begin n_err++; $display("FAIL reinit_step got d=%h v=%0b want d=1 v=1", m_tdata, m_tvalid); end
  endtask

  task automatic test_saturate();
    mode = 2'b00; m_tready = 1'b1;
    do_reset();
    beat(2'b00);
    for (int i = 0; i < 130; i++) begin
      @(negedge clk); s_tvalid = 1'b1; s_tdata = enc(fwd_state(i));
    end
    @(negedge clk); s_tvalid = 1'b0;
    @(negedge clk);
    n_vec++; if (sat_tdata !== 8'h7F) begin n_err++; $display("FAIL sat_max got %h want 7f", sat_tdata); end
    n_vec++; if (wrp_tdata !== 8'h82) begin n_err++; $display("FAIL wrap8 got %h want 82", wrp_tdata); end
    n_vec++; if (m_tdata !== 32'd130) begin n_err++; $display("FAIL wide_130 got %h want 82", m_tdata); end
    n_vec++; if (sat_err !== 16'd0 || sat_drop !== 1'b0) begin n_err++; $display("FAIL sat_flags got e=%0d drop=%0b want 0 0", sat_err, sat_drop); end
  endtask

  initial begin
    rst = 1'b1; lo = 16'hFF9C; hi = 16'd100; mode = 2'b00; clr = 1'b0;
    s_tvalid = 1'b0; s_tdata = 32'd0; m_tready = 1'b1;
    test_reset();
    test_init();
    test_x4();
    test_x2_x1();
    test_hysteresis();
    test_back_to_back();
    test_drop_and_reset();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
